// File: rtl/dmac_channel_arbiter.sv
// ---- dmac_channel_arbiter : DMA channel request arbiter (round-robin / fixed priority) ----
// ---- Rev 1.0 ----
`default_nettype none

module dmac_channel_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int FIXED_PRIO = 0,
  localparam int CW        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] DmacReq,
  input  logic [NUM_CH-1:0] ChCfgValid,
  input  logic [NUM_CH-1:0] ChDone,
  input  logic              Bus_Grant,
  output logic              Bus_Req,
  output logic [NUM_CH-1:0] ChEnable,
  output logic [NUM_CH-1:0] ReqAck,
  output logic [CW-1:0]     ActiveCh,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);
  localparam logic [CW-1:0]     LAST_CH  = CW'(NUM_CH - 1);

  state_t            state;
  logic [CW-1:0]     winner;
  logic [CW-1:0]     ptr;
  logic [NUM_CH-1:0] eligible;
  logic [CW-1:0]     pick;
  logic              found;
  int                idx;

  assign eligible = DmacReq & ChCfgValid;

  // First eligible channel, scanning upward from ptr (or from 0 in fixed mode).
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (FIXED_PRIO != 0) idx = i;
      else                 idx = (int'(ptr) + i) % NUM_CH;
      if (!found && eligible[idx[CW-1:0]]) begin
        pick  = idx[CW-1:0];
        found = 1'b1;
      end
    end
  end

  assign ActiveCh = winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      Bus_Req  <= 1'b0;
      ChEnable <= '0;
      ReqAck   <= '0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ReqAck <= '0;
          if (found) begin
            winner  <= pick;
            state   <= REQ;
            Bus_Req <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        REQ: begin
          if (!eligible[winner]) begin
            state   <= IDLE;
            Bus_Req <= 1'b0;
            Busy    <= 1'b0;
          end else if (Bus_Grant) begin
            state    <= XFER;
            ChEnable <= ONE_HOT0 << winner;
          end
        end
        XFER: begin
          // Completion takes precedence over a simultaneous grant loss.
          if (ChDone[winner]) begin
            state    <= ACK;
            Bus_Req  <= 1'b0;
            ChEnable <= '0;
            ReqAck   <= ONE_HOT0 << winner;
          end else if (!Bus_Grant) begin
            state    <= REQ;
            ChEnable <= '0;
          end
        end
        ACK: begin
          state  <= IDLE;
          ReqAck <= '0;
          Busy   <= 1'b0;
          ptr    <= (winner == LAST_CH) ? '0 : winner + CW'(1);
        end
        default: begin
          state    <= IDLE;
          Bus_Req  <= 1'b0;
          ChEnable <= '0;
          ReqAck   <= '0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmac_channel_arbiter.sv
// ---- tb_dmac_channel_arbiter : directed bench, round-robin and fixed-priority instances ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_dmac_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, cfg, done;
  logic       grant;

  logic       rr_bus_req, fp_bus_req, rr_busy, fp_busy;
  logic [1:0] rr_en, fp_en, rr_ack, fp_ack;
  logic [0:0] rr_act, fp_act;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmac_channel_arbiter #(.NUM_CH(2), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .DmacReq(req), .ChCfgValid(cfg), .ChDone(done),
    .Bus_Grant(grant), .Bus_Req(rr_bus_req), .ChEnable(rr_en), .ReqAck(rr_ack),
    .ActiveCh(rr_act), .Busy(rr_busy)
  );

  dmac_channel_arbiter #(.NUM_CH(2), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .DmacReq(req), .ChCfgValid(cfg), .ChDone(done),
    .Bus_Grant(grant), .Bus_Req(fp_bus_req), .ChEnable(fp_en), .ReqAck(fp_ack),
    .ActiveCh(fp_act), .Busy(fp_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; cfg = '0; done = '0; grant = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Active inputs during reset must be ignored.
    rst = 1'b1; req = 2'b11; cfg = 2'b11; done = 2'b11; grant = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({rr_bus_req, rr_en, rr_ack, rr_act, rr_busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_rr: got %b want 0000000", {rr_bus_req, rr_en, rr_ack, rr_act, rr_busy});
    end
    n_cmp++;
    if ({fp_bus_req, fp_en, fp_ack, fp_act, fp_busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_fp: got %b want 0000000", {fp_bus_req, fp_en, fp_ack, fp_act, fp_busy});
    end
    rst = 1'b0; req = '0; cfg = '0; done = '0; grant = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    cfg = 2'b01; req = 2'b01; grant = 1'b0;
    tick();
    n_cmp++;
    if ({rr_bus_req, rr_busy, rr_en} !== 4'b1100) begin
      n_err++; $display("FAIL single_req: got {bus_req,busy,en}=%b want 1100", {rr_bus_req, rr_busy, rr_en});
    end
    tick();
    n_cmp++;
    if ({rr_bus_req, rr_en} !== 3'b100) begin
      n_err++; $display("FAIL single_wait: got {bus_req,en}=%b want 100", {rr_bus_req, rr_en});
    end
    grant = 1'b1;
    tick();
    n_cmp++;
    if (rr_en !== 2'b01 || fp_en !== 2'b01) begin
      n_err++; $display("FAIL single_enable: got rr=%b fp=%b want 01", rr_en, fp_en);
    end
    done = 2'b01; req = 2'b00;
    tick();
    done = 2'b00;
    n_cmp++;
    if ({rr_ack, rr_bus_req, rr_en, rr_busy} !== 6'b010001) begin
      n_err++; $display("FAIL single_ack: got {ack,bus_req,en,busy}=%b want 010001", {rr_ack, rr_bus_req, rr_en, rr_busy});
    end
    tick();
    n_cmp++;
    if ({rr_ack, rr_bus_req, rr_busy} !== 4'b0000) begin
      n_err++; $display("FAIL single_idle: got {ack,bus_req,busy}=%b want 0000", {rr_ack, rr_bus_req, rr_busy});
    end
    grant = 1'b0;
  endtask

  task automatic test_fairness();
    logic [0:0] exp_ch;
    logic [1:0] exp_oh;
    apply_reset();
    cfg = 2'b11; req = 2'b11; grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ch = k[0];
      exp_oh = 2'b01 << k[0];
      for (int c = 0; c < 8 && rr_en === 2'b00; c++) tick();
      n_cmp++;
      if (rr_en === 2'b00) begin
        n_err++; $display("FAIL fair_timeout: xfer %0d never enabled", k);
      end
      n_cmp++;
      if (rr_act !== exp_ch || rr_en !== exp_oh) begin
        n_err++; $display("FAIL fair_rr_win: xfer %0d got act=%0d en=%b want act=%0d en=%b", k, rr_act, rr_en, exp_ch, exp_oh);
      end
      n_cmp++;
      if (fp_act !== 1'b0 || fp_en !== 2'b01) begin
        n_err++; $display("FAIL fair_fp_win: xfer %0d got act=%0d en=%b want act=0 en=01", k, fp_act, fp_en);
      end
      done = 2'b11;
      tick();
      done = 2'b00;
      n_cmp++;
      if (rr_ack !== exp_oh || fp_ack !== 2'b01 || rr_bus_req !== 1'b0) begin
        n_err++; $display("FAIL fair_ack: xfer %0d got rr=%b fp=%b bus_req=%b want rr=%b fp=01 bus_req=0", k, rr_ack, fp_ack, rr_bus_req, exp_oh);
      end
      tick();
      n_cmp++;
      if (rr_bus_req !== 1'b0 || rr_ack !== 2'b00) begin
        n_err++; $display("FAIL fair_gap: xfer %0d got bus_req=%b ack=%b want 0 00", k, rr_bus_req, rr_ack);
      end
    end
    req = '0; grant = 1'b0;
  endtask

  task automatic test_grant_loss();
    apply_reset();
    cfg = 2'b11; req = 2'b10; grant = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (rr_en !== 2'b10 || rr_act !== 1'b1) begin
      n_err++; $display("FAIL gl_start: got en=%b act=%0d want en=10 act=1", rr_en, rr_act);
    end
    req = 2'b11; grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({rr_en, rr_bus_req, rr_busy, rr_act} !== 5'b00111) begin
        n_err++; $display("FAIL gl_pause: cycle %0d got {en,bus_req,busy,act}=%b want 00111", k, {rr_en, rr_bus_req, rr_busy, rr_act});
      end
    end
    grant = 1'b1;
    tick();
    n_cmp++;
    if (rr_en !== 2'b10) begin
      n_err++; $display("FAIL gl_resume: got en=%b want 10", rr_en);
    end
    done = 2'b01;
    tick();
    n_cmp++;
    if (rr_en !== 2'b10 || rr_ack !== 2'b00) begin
      n_err++; $display("FAIL gl_foreign_done: got en=%b ack=%b want 10 00", rr_en, rr_ack);
    end
    done = 2'b10; grant = 1'b0;
    tick();
    done = 2'b00; req = 2'b00;
    n_cmp++;
    if (rr_ack !== 2'b10 || rr_en !== 2'b00 || rr_bus_req !== 1'b0) begin
      n_err++; $display("FAIL gl_done_vs_grant: got ack=%b en=%b bus_req=%b want 10 00 0", rr_ack, rr_en, rr_bus_req);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    apply_reset();
    cfg = 2'b01; req = 2'b10; grant = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rr_bus_req !== 1'b0 || rr_busy !== 1'b0) begin
      n_err++; $display("FAIL wd_ineligible: got bus_req=%b busy=%b want 0 0", rr_bus_req, rr_busy);
    end
    req = 2'b01;
    tick();
    n_cmp++;
    if (rr_bus_req !== 1'b1) begin
      n_err++; $display("FAIL wd_request: got bus_req=%b want 1", rr_bus_req);
    end
    req = 2'b00;
    tick();
    n_cmp++;
    if ({rr_bus_req, rr_busy, rr_ack} !== 4'b0000) begin
      n_err++; $display("FAIL wd_drop: got {bus_req,busy,ack}=%b want 0000", {rr_bus_req, rr_busy, rr_ack});
    end
    tick();
    n_cmp++;
    if (rr_ack !== 2'b00 || rr_bus_req !== 1'b0) begin
      n_err++; $display("FAIL wd_no_ack: got ack=%b bus_req=%b want 00 0", rr_ack, rr_bus_req);
    end
    cfg = 2'b11; req = 2'b11;
    tick();
    n_cmp++;
    if (rr_act !== 1'b0 || rr_bus_req !== 1'b1) begin
      n_err++; $display("FAIL wd_ptr_kept: got act=%0d bus_req=%b want 0 1", rr_act, rr_bus_req);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_xfer();
    apply_reset();
    cfg = 2'b11; req = 2'b11; grant = 1'b1;
    tick();
    tick();
    done = 2'b11;
    tick();
    done = 2'b00;
    for (int c = 0; c < 8 && rr_en === 2'b00; c++) tick();
    n_cmp++;
    if (rr_en !== 2'b10 || rr_act !== 1'b1) begin
      n_err++; $display("FAIL rm_second: got en=%b act=%0d want 10 1", rr_en, rr_act);
    end
    rst = 1'b1; done = 2'b10;
    tick();
    n_cmp++;
    if ({rr_bus_req, rr_en, rr_ack, rr_act, rr_busy} !== 7'b0) begin
      n_err++; $display("FAIL rm_outputs: got %b want 0000000", {rr_bus_req, rr_en, rr_ack, rr_act, rr_busy});
    end
    rst = 1'b0; done = 2'b00;
    tick();
    n_cmp++;
    if (rr_act !== 1'b0 || rr_bus_req !== 1'b1 || rr_busy !== 1'b1) begin
      n_err++; $display("FAIL rm_restart: got act=%0d bus_req=%b busy=%b want 0 1 1", rr_act, rr_bus_req, rr_busy);
    end
    tick();
    n_cmp++;
    if (rr_en !== 2'b01) begin
      n_err++; $display("FAIL rm_enable: got en=%b want 01", rr_en);
    end
    req = '0; grant = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; cfg = '0; done = '0; grant = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_grant_loss();
    test_withdrawal();
    test_reset_mid_xfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
